// File: rtl/comp_sched_pkg.sv
// Shared types and constants for the comparison-layer scheduler.
package comp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int unsigned VEC_LEN          = 12;
  localparam int unsigned CL_LOAD_CYCLES   = 5;
  localparam int unsigned DATA_LEN_DEFAULT = 8;

endpackage

// File: rtl/comp_sched_rr_arbiter.sv
// Combinational round-robin search: first set req strictly after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);

  int unsigned pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      pos = (32'(ptr_i) + i) % N;
      if (!any_o && ((req_i >> pos) & N'(1)) != '0) begin
        any_o = 1'b1;
        gnt_o = N'(1) << pos;
        idx_o = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/comp_sched.sv
// Round-robin sharing of one 12-class compare layer between NUM_REQ streams.
// Optional RUN timeout abort enabled by defining COMP_SCHED_TIMEOUT_EN.
module comp_sched
  import comp_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned DATA_LEN = DATA_LEN_DEFAULT,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*VEC_LEN*DATA_LEN-1:0] req_d1,
  input  logic [NUM_REQ*VEC_LEN*DATA_LEN-1:0] req_d2,
  output logic [NUM_REQ-1:0]               gnt,
  output logic                             done,
  output logic [3:0]                       result,
  output logic [ID_W-1:0]                  result_id,
  output logic                             err,
  output logic                             cl_load,
  output logic [VEC_LEN*DATA_LEN-1:0]      cl_d1,
  output logic [VEC_LEN*DATA_LEN-1:0]      cl_d2,
  input  logic                             cl_valid,
  input  logic [3:0]                       cl_q
);

  localparam int unsigned VEC_W = VEC_LEN * DATA_LEN;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             cl_load_q, cl_load_d;
  logic             done_q, done_d;
  logic             err_d;
  logic [3:0]       result_q, result_d;
  logic [ID_W-1:0]  result_id_q, result_id_d;
  logic [VEC_W-1:0] cl_d1_q, cl_d1_d;
  logic [VEC_W-1:0] cl_d2_q, cl_d2_d;
  logic             timeout_hit;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;
  logic [NUM_REQ-1:0] gnt_c;
  logic [VEC_W-1:0]   sel_d1, sel_d2;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    sel_d1 = '0;
    sel_d2 = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_d1 = req_d1[i*VEC_W +: VEC_W];
        sel_d2 = req_d2[i*VEC_W +: VEC_W];
      end
    end
  end

`ifdef COMP_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q;
  logic          err_q;

  // Counter is zero in the first RUN cycle; the TIMEOUT-th RUN cycle aborts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= (state_q == RUN) ? tcnt_q + TW'(1) : '0;
      err_q  <= err_d;
    end
  end

  assign timeout_hit = (tcnt_q == TW'(TIMEOUT - 1));
  assign err         = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cl_load_d   = cl_load_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    result_d    = result_q;
    result_id_d = result_id_q;
    cl_d1_d     = cl_d1_q;
    cl_d2_d     = cl_d2_q;
    gnt_c       = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_c     = arb_gnt;
          cl_d1_d   = sel_d1;
          cl_d2_d   = sel_d2;
          ptr_d     = arb_idx;
          id_d      = arb_idx;
          cl_load_d = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (cl_valid) begin
          result_d    = cl_q;
          result_id_d = id_q;
          done_d      = 1'b1;
          cl_load_d   = 1'b0;
          state_d     = GAP;
        end else if (timeout_hit) begin
          err_d     = 1'b1;
          cl_load_d = 1'b0;
          state_d   = GAP;
        end
      end
      GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      cl_load_q   <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_id_q <= '0;
      cl_d1_q     <= '0;
      cl_d2_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cl_load_q   <= cl_load_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_id_q <= result_id_d;
      cl_d1_q     <= cl_d1_d;
      cl_d2_q     <= cl_d2_d;
    end
  end

  // Grant is combinational from req, so it is masked while reset is held.
  assign gnt       = rst_n ? gnt_c : '0;
  assign done      = done_q;
  assign result    = result_q;
  assign result_id = result_id_q;
  assign cl_load   = cl_load_q;
  assign cl_d1     = cl_d1_q;
  assign cl_d2     = cl_d2_q;

endmodule

// File: doc/comp_sched.md
Name: comp_sched

Overview:
- Round-robin scheduler that shares one final comparison layer (12-class adder + argmax, 4-bit class index) between NUM_REQ inference streams.
- Each stream presents two 12-element partial-score vectors.
- comp_sched arbitrates between streams and latches the winner's vectors. It drives the layer's load/d1/d2, waits for the layer's valid and captures the class index. It then returns the index to the winner and inserts the load-low gap the layer needs to clear its internal counter.
- Sits between the network's last two branches and the result/host interface.

Parameters:
- NUM_REQ, 4, number of requesting streams (1..8).
- ID_W, 2, width of requester id; must be >= ceil(log2(NUM_REQ)), minimum 1.
- DATA_LEN, `data_len, width of one score element (from num_data.v).
- TIMEOUT, 15, maximum RUN cycles without layer valid before abort (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-stream request, level
- req_d1  in  NUM_REQ*12*DATA_LEN  stream i vector 1 at slice i*12*DATA_LEN
- req_d2  in  NUM_REQ*12*DATA_LEN  stream i vector 2, same slicing
- gnt  out  NUM_REQ  one-hot accept pulse; stream's vectors sampled this cycle
- done  out  1  one-cycle result pulse
- result  out  4  class index, valid with done, held until next done
- result_id  out  ID_W  stream that owns result
- err  out  1  one-cycle timeout pulse (0 when feature disabled)
- cl_load  out  1  layer load, registered
- cl_d1  out  12*DATA_LEN  layer vector 1, registered, stable while cl_load=1
- cl_d2  out  12*DATA_LEN  layer vector 2, same
- cl_valid  in  1  layer valid
- cl_q  in  4  layer class index

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; gnt, done, err, cl_load, result, result_id, cl_d1 and cl_d2 all reset to 0.
  - RR pointer = NUM_REQ-1, so stream 0 has first priority.
- FSM states: IDLE, RUN, GAP.
- IDLE:
  - If any req is high, pick the winner w = first set req searching upward from ptr+1, wrapping modulo NUM_REQ.
  - gnt[w]=1 combinationally in this cycle.
  - On the clock edge: latch req_d1/req_d2 slice w into cl_d1/cl_d2, set ptr=w and id=w, set cl_load=1, go to RUN.
  - No req: stay in IDLE; gnt=0.
- RUN:
  - cl_load=1, and cl_d1/cl_d2 are frozen.
  - When cl_valid=1 is sampled: on that edge register result=cl_q, result_id=id, done=1 for the next cycle, cl_load=0, and go to GAP.
  - The layer raises valid after 5 load edges, so with grant in cycle n, RUN covers n+1..n+6 and done is high in n+7.
- GAP:
  - Exactly one cycle with cl_load=0; this clears the layer's counter and valid. Then go to IDLE.
  - The next grant occurs no earlier than n+8, giving a service period of 8 cycles.
- Request handling:
  - req changes during RUN/GAP are ignored; arbitration happens only in IDLE.
  - A stream still holding req after its done competes again with the lowest priority.
  - req may drop in the cycle after gnt.
- NUM_REQ=1: pointer logic degenerates; stream 0 is always the winner.
- Asynchronous reset mid-RUN:
  - Everything is aborted; no done is issued.
  - cl_load=0 immediately, so the layer also sees load low.

Optional Feature:
- Macro COMP_SCHED_TIMEOUT_EN.
- When defined:
  - A RUN cycle counter is cleared on RUN entry.
  - If the counter reaches TIMEOUT with no cl_valid, err pulses for one cycle, cl_load=0, there is no done, result is unchanged, and the FSM goes to GAP.
  - cl_valid sampled in the same cycle as the TIMEOUT count wins: done is issued and err is not.
- When undefined: RUN waits indefinitely, there is no counter, and err is tied to 0.

Decomposition:
- Shared header comp_sched_defs.vh:
  - state encodings (IDLE=2'd0, RUN=2'd1, GAP=2'd2);
  - VEC_LEN=12;
  - CL_LOAD_CYCLES=5.
  - Included alongside num_data.v.
- One sub-module, rr_arbiter:
  - Combinational search over req from ptr+1.
  - Outputs one-hot grant plus encoded index and any flag.
  - Parameter N.

Test Plan:
- Single request: req=4'b0001 with vectors giving max sum at element 7, grant in cycle n -> gnt=0001 in n; cl_load high n+1..n+6; done, result=7 and result_id=0 in n+7; cl_load=0 in n+7.
- All requests held high from reset -> grants in order 0,1,2,3,0 at 8-cycle spacing; each result_id matches its own vectors' argmax.
- req1 and req3 asserted after stream 1 served (ptr=1) -> stream 3 granted before stream 1.
- Change req_d1 of the winner during RUN -> cl_d1 unchanged and result reflects the latched vectors.
- Assert rst_n=0 at cycle n+3 of a service -> cl_load=0 asynchronously, no done; after release req0 is served from IDLE normally.
- COMP_SCHED_TIMEOUT_EN with TIMEOUT=15 and a layer model that never raises valid -> err pulse after 15 RUN cycles, no done, one GAP cycle, then the next request is granted.
